beatmap_sequencer: RTL and testbench

BEATMAP_SEQUENCER -- requirements
Module: beatmap_sequencer

---
 rtl/beatmap_sequencer.sv | 158 +++++++++++++++
 tb/tb_beatmap_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beatmap_sequencer.sv
// -----------------------------------------------------------------------------
// beatmap_sequencer
//
// Walks a beatmap stored in an external synchronous ROM (1-cycle read
// latency) and offers each 8-bit beat word to a double-buffer writer through
// a data_en/ready handshake. The first entry is fetched right after start.
// Every later entry is fetched on a tempo tick. A tick that arrives while an
// entry is still being fetched or offered is dropped and flagged in overrun.
//
// Parameters
//   ADDR_W   beatmap ROM address width
//   LOOP     1: restart at address 0 after the last entry, 0: stop in DONE
//
// Ports
//   clk       clock, all registers update on its rising edge
//   reset     synchronous active-high reset
//   start     one-cycle pulse, begins a song from IDLE or DONE
//   pause     level, while high ticks are not consumed
//   tick      one-cycle beat strobe from the tempo divider
//   song_len  number of beat entries, sampled on an accepted start
//   rom_addr  registered ROM address
//   rom_data  ROM word, valid one cycle after rom_addr
//   data      registered beat word, one bit per note lane
//   data_en   data offered to the consumer
//   ready     consumer accepts when data_en && ready
//   busy      high in every state except IDLE and DONE
//   done      high in DONE
//   overrun   sticky, set when a tick is lost
// -----------------------------------------------------------------------------
module beatmap_sequencer #(
  parameter int ADDR_W = 8,
  parameter bit LOOP   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              tick,
  input  logic [ADDR_W-1:0] song_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        data,
  output logic              data_en,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT     = 3'd2,
    OFFER    = 3'd3,
    TICKWAIT = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] len_q;
  logic              tick_live;
  logic              last_entry;
  logic              in_flight;

  // A tick only counts when the song is not paused.
  assign tick_live  = tick & ~pause;
  // len_q is never 0 outside IDLE/DONE, so len_q-1 cannot underflow here.
  assign last_entry = (ptr == (len_q - ONE));
  // States in which an entry is still in progress; a live tick here is lost.
  assign in_flight  = (state == FETCH) || (state == WAIT) || (state == OFFER);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rom_addr <= '0;
      data     <= '0;
      data_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      ptr      <= '0;
      len_q    <= '0;
    end else begin
      // No tick queue: a tick arriving mid-entry is simply dropped.
      if (tick_live && in_flight) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            len_q    <= song_len;
            ptr      <= '0;
            rom_addr <= '0;
            overrun  <= 1'b0;
            if (song_len == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              // First entry is fetched immediately, without waiting for a tick.
              state <= FETCH;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end

        FETCH: begin
          // rom_addr already holds ptr; the ROM answers during WAIT.
          state <= WAIT;
        end

        WAIT: begin
          data    <= rom_data;
          data_en <= 1'b1;
          state   <= OFFER;
        end

        OFFER: begin
          // data and data_en stay untouched until the consumer is ready.
          if (ready) begin
            data_en <= 1'b0;
            if (last_entry) begin
              if (LOOP) begin
                ptr      <= '0;
                rom_addr <= '0;
                state    <= TICKWAIT;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              ptr      <= ptr + ONE;
              rom_addr <= ptr + ONE;
              state    <= TICKWAIT;
            end
          end
        end

        TICKWAIT: begin
          if (tick_live) begin
            state <= FETCH;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beatmap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_beatmap_sequencer
//
// Two sequencers (LOOP=0 and LOOP=1) share stimulus and each reads its own
// synchronous ROM port backed by one memory array. A song-level model (entry
// index, cycles left until the next offer, offer flag) predicts every output
// and is compared on each falling edge. Directed scenarios pin the model with
// literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_beatmap_sequencer;

  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset    = 1'b1;
  logic          start    = 1'b0;
  logic          pause    = 1'b0;
  logic          tick     = 1'b0;
  logic          ready    = 1'b1;
  logic [AW-1:0] song_len = '0;

  logic [AW-1:0] a0, a1;
  logic [7:0]    rd0, rd1, d0, d1;
  logic          en0, en1, b0, b1, dn0, dn1, ov0, ov1;

  logic [7:0] rom_mem [256];

  // Synchronous ROM with one cycle of read latency, one port per DUT.
  always @(posedge clk) begin
    rd0 <= rom_mem[a0];
    rd1 <= rom_mem[a1];
  end

  beatmap_sequencer #(.ADDR_W(AW), .LOOP(1'b0)) u0 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .tick(tick),
    .song_len(song_len), .rom_addr(a0), .rom_data(rd0), .data(d0),
    .data_en(en0), .ready(ready), .busy(b0), .done(dn0), .overrun(ov0)
  );

  beatmap_sequencer #(.ADDR_W(AW), .LOOP(1'b1)) u1 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .tick(tick),
    .song_len(song_len), .rom_addr(a1), .rom_data(rd1), .data(d1),
    .data_en(en1), .ready(ready), .busy(b1), .done(dn1), .overrun(ov1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Song-level model: cnt counts cycles until the entry is offered (2 after a
  // start or an accepted tick), idx is the entry being played and doubles as
  // the expected ROM address.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       busy;
    logic       done;
    logic       ovr;
    logic       offering;
    int         cnt;
    logic [7:0] idx;
    logic [7:0] len;
    logic [7:0] data;
  } mdl_t;

  function automatic mdl_t mstep(input mdl_t m, input bit loop, input logic rst,
                                 input logic st, input logic ps, input logic tk,
                                 input logic rdy, input logic [7:0] sl);
    mdl_t n;
    bit   live;
    n    = m;
    live = tk && !ps;
    if (rst) begin
      n.busy = 0; n.done = 0; n.ovr = 0; n.offering = 0;
      n.cnt = 0; n.idx = 0; n.len = 0; n.data = 0;
      return n;
    end
    if (m.busy && (m.cnt > 0 || m.offering) && live) n.ovr = 1;
    if (!m.busy) begin
      if (st) begin
        n.len = sl;
        n.idx = 0;
        n.ovr = 0;
        if (sl == 0) begin
          n.done = 1;
        end else begin
          n.done = 0;
          n.busy = 1;
          n.cnt  = 2;
        end
      end
    end else if (m.cnt > 0) begin
      n.cnt = m.cnt - 1;
      if (n.cnt == 0) begin
        n.offering = 1;
        n.data     = rom_mem[m.idx];
      end
    end else if (m.offering) begin
      if (rdy) begin
        n.offering = 0;
        if (int'(m.idx) == int'(m.len) - 1) begin
          if (loop) begin
            n.idx = 0;
          end else begin
            n.busy = 0;
            n.done = 1;
          end
        end else begin
          n.idx = m.idx + 8'd1;
        end
      end
    end else if (live) begin
      n.cnt = 2;
    end
    return n;
  endfunction

  mdl_t m0, m1;

  always @(posedge clk) begin
    m0 = mstep(m0, 1'b0, reset, start, pause, tick, ready, song_len);
    m1 = mstep(m1, 1'b1, reset, start, pause, tick, ready, song_len);
  end

  task automatic cmp_dut(input string tag, input logic [7:0] a, input logic [7:0] d,
                         input logic en, input logic b, input logic dn, input logic ov,
                         input mdl_t m);
    chk({tag, ".rom_addr"}, 32'(a),  32'(m.idx));
    chk({tag, ".data"},     32'(d),  32'(m.data));
    chk({tag, ".data_en"},  32'(en), 32'(m.offering));
    chk({tag, ".busy"},     32'(b),  32'(m.busy));
    chk({tag, ".done"},     32'(dn), 32'(m.done));
    chk({tag, ".overrun"},  32'(ov), 32'(m.ovr));
  endtask

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_dut("cyc.u0", a0, d0, en0, b0, dn0, ov0, m0);
      cmp_dut("cyc.u1", a1, d1, en1, b1, dn1, ov1, m1);
    end
  end

  // Transfer monitor: one line per accepted beat word.
  logic [15:0] q0 [$];
  logic [7:0]  q1a [$];
  int          n_en0 = 0;
  int          n_en1 = 0;

  always @(negedge clk) begin
    if (en0) n_en0++;
    if (en1) n_en1++;
    if (en0 && ready) begin
      q0.push_back({a0, d0});
      $display("xfer u0 addr=%0d data=%02h", a0, d0);
    end
    if (en1 && ready) begin
      q1a.push_back(a1);
      $display("xfer u1 addr=%0d data=%02h", a1, d1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; tick = 1'b0; pause = 1'b0; ready = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic clear_mon();
    q0.delete();
    q1a.delete();
    n_en0 = 0;
    n_en1 = 0;
  endtask

  initial begin
    logic [15:0] g16;
    logic [7:0]  g8;
    logic [7:0]  exp_basic [3];
    logic [7:0]  exp_loop  [4];

    exp_basic = '{8'h81, 8'h42, 8'h24};
    exp_loop  = '{8'd0, 8'd1, 8'd0, 8'd1};

    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    rom_mem[0] = 8'h81;
    rom_mem[1] = 8'h42;
    rom_mem[2] = 8'h24;

    cmp_en = 1'b1;
    do_reset();

    // Reset state.
    chk("rst.busy", 32'(b0), 0);
    chk("rst.done", 32'(dn0), 0);
    chk("rst.data_en", 32'(en0), 0);
    chk("rst.overrun", 32'(ov0), 0);
    chk("rst.rom_addr", 32'(a0), 0);
    chk("rst.data", 32'(d0), 0);

    // Basic song of three entries, tick every 10 cycles.
    clear_mon();
    song_len = 8'd3; ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("lat.c1.data_en", 32'(en0), 0);
    chk("lat.c1.busy", 32'(b0), 1);
    cyc();
    cyc();
    chk("lat.c3.data_en", 32'(en0), 1);
    chk("lat.c3.data", 32'(d0), 32'h81);
    for (int k = 0; k < 60; k++) begin
      tick = (k % 10 == 5);
      cyc();
    end
    tick = 1'b0;
    chk("basic.done", 32'(dn0), 1);
    chk("basic.overrun", 32'(ov0), 0);
    chk("basic.xfers", 32'(q0.size()), 3);
    chk("basic.en_cycles", 32'(n_en0), 3);
    for (int i = 0; i < 3; i++) begin
      g16 = (i < q0.size()) ? q0[i] : 16'hxxxx;
      chk($sformatf("basic.addr%0d", i), 32'(g16[15:8]), 32'(i));
      chk($sformatf("basic.data%0d", i), 32'(g16[7:0]), 32'(exp_basic[i]));
    end

    // Backpressure: ready low for five OFFER cycles.
    do_reset();
    clear_mon();
    song_len = 8'd3; ready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("bp.hold.data_en", 32'(en0), 1);
      chk("bp.hold.data", 32'(d0), 32'h81);
      cyc();
    end
    chk("bp.last.data_en", 32'(en0), 1);
    ready = 1'b1;
    cyc();
    chk("bp.drop.data_en", 32'(en0), 0);
    chk("bp.rom_addr", 32'(a0), 1);
    chk("bp.en_cycles", 32'(n_en0), 6);

    // Overrun: tick lands in the WAIT cycle of entry 1.
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("ovr.flag", 32'(ov0), 1);
    chk("ovr.data_en", 32'(en0), 1);
    chk("ovr.data", 32'(d0), 32'h42);
    repeat (6) cyc();
    chk("ovr.idle.data_en", 32'(en0), 0);
    chk("ovr.idle.rom_addr", 32'(a0), 2);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    cyc();
    chk("ovr.next.data_en", 32'(en0), 1);
    chk("ovr.next.data", 32'(d0), 32'h24);

    // Pause and loop on the LOOP=1 instance.
    do_reset();
    clear_mon();
    song_len = 8'd2; ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      repeat (4) cyc();
    end
    chk("pause.rom_addr", 32'(a1), 1);
    chk("pause.en_cycles", 32'(n_en1), 1);
    chk("pause.busy", 32'(b1), 1);
    pause = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick = (k % 10 == 0);
      cyc();
    end
    tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      g8 = (i < q1a.size()) ? q1a[i] : 8'hxx;
      chk($sformatf("loop.addr%0d", i), 32'(g8), 32'(exp_loop[i]));
    end
    chk("loop.done", 32'(dn1), 0);
    chk("loop.overrun", 32'(ov1), 0);

    // Edges: empty song, start while busy, reset mid-OFFER.
    do_reset();
    clear_mon();
    song_len = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("empty.done", 32'(dn0), 1);
    chk("empty.data_en", 32'(en0), 0);
    chk("empty.busy", 32'(b0), 0);
    song_len = 8'd3; ready = 1'b0; start = 1'b1;
    cyc();
    song_len = 8'd5;
    cyc();
    start = 1'b0;
    chk("busystart.busy", 32'(b0), 1);
    chk("busystart.rom_addr", 32'(a0), 0);
    cyc();
    chk("busystart.data_en", 32'(en0), 1);
    reset = 1'b1; ready = 1'b1; tick = 1'b1; start = 1'b1;
    cyc();
    reset = 1'b0; tick = 1'b0; start = 1'b0;
    chk("rstoffer.data_en", 32'(en0), 0);
    chk("rstoffer.data", 32'(d0), 0);
    chk("rstoffer.busy", 32'(b0), 0);
    chk("rstoffer.done", 32'(dn0), 0);
    chk("rstoffer.rom_addr", 32'(a0), 0);
    chk("rstoffer.overrun", 32'(ov0), 0);

    // Randomized phase, checked every cycle against the model.
    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 29) == 0);
      tick  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      ready = ($urandom_range(0, 9) < 7);
      song_len = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 4));
      cyc();
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
